// File: rtl/decoder_4to10.sv
`default_nettype none
// ============================================================================
// decoder_4to10 : registered BCD-to-decimal one-hot decoder with valid flag
// Revision 1.0 - initial release
// ============================================================================
module decoder_4to10 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] din,
  input  logic       en,
  output logic [9:0] dout,
  output logic       out_en
);

  localparam int unsigned NUM_DIGITS = 10;

  logic [NUM_DIGITS-1:0] dec_next;
  logic                  valid_next;

  // Codes 10..15 match no digit, so an invalid code naturally decodes to all-zero.
  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      assign dec_next[k] = en && (din == 4'(k));
    end
  endgenerate

  assign valid_next = en && (din <= 4'd9);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout   <= '0;
      out_en <= 1'b0;
    end else begin
      dout   <= dec_next;
      out_en <= valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_4to10.sv
`default_nettype none
// ============================================================================
// tb_decoder_4to10 : directed scoreboard bench for the BCD one-hot decoder
// Revision 1.0 - initial release
// ============================================================================
module tb_decoder_4to10;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] din  = 4'd0;
  logic       en   = 1'b0;
  logic [9:0] dout;
  logic       out_en;

  int checks = 0;
  int errors = 0;

  // Each entry packs {expected out_en, expected dout}.
  logic [10:0] sb[$];

  decoder_4to10 dut (
    .clk    (clk),
    .rstn   (rstn),
    .din    (din),
    .en     (en),
    .dout   (dout),
    .out_en (out_en)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] model(input logic m_en, input logic [3:0] m_din);
    logic [9:0] onehot;
    onehot = '0;
    if (m_en && m_din < 4'd10) begin
      onehot[m_din] = 1'b1;
      return {1'b1, onehot};
    end
    return {1'b0, 10'h000};
  endfunction

  task automatic check(input string tag, input logic [9:0] exp_d, input logic exp_v);
    checks++;
    assert (dout === exp_d && out_en === exp_v &&
            (out_en ? ($countones(dout) == 1) : (dout == 10'h000)))
    else begin
      errors++;
      $error("FAIL %s observed dout=%h out_en=%b expected dout=%h out_en=%b",
             tag, dout, out_en, exp_d, exp_v);
    end
  endtask

  // Called just after a rising edge: drive, queue the prediction, compare after next edge.
  task automatic step(input string tag, input logic s_en, input logic [3:0] s_din);
    logic [10:0] exp;
    en  = s_en;
    din = s_din;
    sb.push_back(model(s_en, s_din));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, exp[9:0], exp[10]);
    end
  endtask

  initial begin
    // Reset asserted before any clock edge, with an active code on the inputs
    en  = 1'b1;
    din = 4'd3;
    #1 rstn = 1'b0;
    #1 check("reset_async", 10'h000, 1'b0);
    @(posedge clk); #1 check("reset_hold1", 10'h000, 1'b0);
    @(posedge clk); #1 check("reset_hold2", 10'h000, 1'b0);
    #2 rstn = 1'b1;
    #1 check("reset_release_no_edge", 10'h000, 1'b0);
    @(posedge clk); #1;
    check("first_edge_after_release", 10'h008, 1'b1);

    // Disabled: every code gives zero
    for (int i = 0; i < 16; i++) step("disabled", 1'b0, 4'(i));

    // Valid sweep
    for (int i = 0; i < 10; i++) step("valid", 1'b1, 4'(i));

    // Invalid codes then wrap to zero
    for (int i = 10; i < 16; i++) step("invalid", 1'b1, 4'(i));
    step("wrap_15_to_0", 1'b1, 4'd0);

    // Enable drop and restore
    step("en_on_5", 1'b1, 4'd5);
    step("en_drop", 1'b0, 4'd5);
    step("en_restore", 1'b1, 4'd5);

    // Back-to-back random codes with random enable
    for (int i = 0; i < 20; i++)
      step("random", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));

    // Asynchronous reset pulse between edges
    step("pre_reset_7", 1'b1, 4'd7);
    #2 rstn = 1'b0;
    #1 check("midrun_async_clear", 10'h000, 1'b0);
    sb.delete();
    #1 rstn = 1'b1;
    #0.5 check("midrun_release_no_edge", 10'h000, 1'b0);
    @(posedge clk); #1;
    check("midrun_recover", 10'h080, 1'b1);
    step("post_reset_9", 1'b1, 4'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
